// File: rtl/accel_fir_mc.sv
// rtl/accel_fir_mc.sv - multi-channel time-multiplexed FIR filter for accelerometer samples
// Optional FIR_SATURATE_EN: clamp rounded results instead of two's-complement wrap.
module accel_fir_mc #(
    parameter int CHANNELS   = 3,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int TAPS       = 8,
    parameter int FRAC       = 15,
    parameter int SAMPLE_DIV = 50000
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic                         coef_we,
    input  logic [$clog2(TAPS)-1:0]      coef_addr,
    input  logic [COEF_W-1:0]            coef_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         busy,
    output logic                         sample_tick
);

    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int TAP_W  = $clog2(TAPS);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TICK_W = $clog2(SAMPLE_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [COEF_W-1:0] COEF_INIT = COEF_W'((1 << FRAC) / TAPS);
    localparam logic signed [ACC_W:0]    RND       = (ACC_W + 1)'(1) << (FRAC - 1);
`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 1 - DATA_W){1'b0}}, 1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 1 - DATA_W){1'b1}}, 1'b1, {(DATA_W - 1){1'b0}}};
`endif

    logic [1:0]                state;
    logic [CH_W-1:0]           ch_idx;
    logic [TAP_W-1:0]          tap_idx;
    logic signed [DATA_W-1:0]  dline [CHANNELS][TAPS];
    logic signed [COEF_W-1:0]  coef  [TAPS];
    logic signed [ACC_W-1:0]   acc   [CHANNELS];
    logic [TICK_W-1:0]         tick_cnt;

    logic                      accept;
    logic                      last_tap;
    logic                      last_ch;
    logic signed [PROD_W-1:0]  x_ext;
    logic signed [PROD_W-1:0]  c_ext;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_next;

    // Round half up, arithmetic shift, then either clamp or wrap to DATA_W.
    function automatic logic [DATA_W-1:0] round_scale(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SATURATE_EN
        logic signed [ACC_W:0] s;
        s = ($signed({a[ACC_W-1], a}) + RND) >>> FRAC;
        if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < SAT_MIN) begin
            s = SAT_MIN;
        end
        return s[DATA_W-1:0];
`else
        return DATA_W'(($signed({a[ACC_W-1], a}) + RND) >>> FRAC);
`endif
    endfunction

    assign in_ready    = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign out_valid   = (state == S_OUT);
    assign accept      = in_valid && (state == S_IDLE);
    assign last_tap    = (tap_idx == TAP_W'(TAPS - 1));
    assign last_ch     = (ch_idx == CH_W'(CHANNELS - 1));
    assign sample_tick = (tick_cnt == TICK_W'(SAMPLE_DIV - 1));

    assign x_ext    = PROD_W'(dline[ch_idx][tap_idx]);
    assign c_ext    = PROD_W'(coef[tap_idx]);
    assign prod     = x_ext * c_ext;
    // Tap 0 starts a fresh sum for the channel; no separate clear cycle needed.
    assign acc_base = (tap_idx == '0) ? '0 : acc[ch_idx];
    assign acc_next = acc_base + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= S_IDLE;
            ch_idx   <= '0;
            tap_idx  <= '0;
            out_data <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state   <= S_MAC;
                        ch_idx  <= '0;
                        tap_idx <= '0;
                    end
                end
                S_MAC: begin
                    acc[ch_idx] <= acc_next;
                    if (last_tap) begin
                        tap_idx <= '0;
                        if (last_ch) begin
                            ch_idx <= '0;
                            state  <= S_ROUND;
                        end else begin
                            ch_idx <= ch_idx + CH_W'(1);
                        end
                    end else begin
                        tap_idx <= tap_idx + TAP_W'(1);
                    end
                end
                S_ROUND: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        out_data[c*DATA_W +: DATA_W] <= round_scale(acc[c]);
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The oldest sample falls off the end of each line.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    dline[c][t] <= '0;
                end
            end
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = TAPS - 1; t > 0; t--) begin
                    dline[c][t] <= dline[c][t-1];
                end
                dline[c][0] <= in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Writes outside IDLE are dropped so the MAC never sees a coefficient change mid-vector.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int t = 0; t < TAPS; t++) begin
                coef[t] <= COEF_INIT;
            end
        end else if (coef_we && (state == S_IDLE)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

endmodule

// File: tb/tb_accel_fir_mc.sv
// tb/tb_accel_fir_mc.sv - directed table-driven bench for accel_fir_mc
`timescale 1ns/1ps
module tb_accel_fir_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_data = '0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_data;
    logic        busy;
    logic        sample_tick;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [15:0] d0, d1, d2;
        logic signed [15:0] e0, e1, e2;
    } vec_t;
    vec_t vecs [11];

    always #5 clk = ~clk;

    accel_fir_mc dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_data     (coef_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .sample_tick   (sample_tick)
    );

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic send(input logic [47:0] d, input bit we0, input bit we_mid,
                        input logic [2:0] ca, input logic [15:0] cd,
                        output int lat, output logic [47:0] r);
        int n;
        in_data = d; in_valid = 1'b1;
        coef_we = we0; coef_addr = ca; coef_data = cd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we = we_mid;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            coef_we = 1'b0;
        end
        lat = n;
        r = out_data;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        bit seen;
        bit stable;
        logic [47:0] r;
        logic signed [15:0] exp_sat;
`ifdef FIR_SATURATE_EN
        exp_sat = 16'sh7FFF;
`else
        exp_sat = 16'shBFFF;
`endif
        vecs[0]  = '{1000, 0, 0, 125, 0, 0};
        vecs[1]  = '{1000, 0, 0, 250, 0, 0};
        vecs[2]  = '{1000, 0, 0, 375, 0, 0};
        vecs[3]  = '{1000, 0, 0, 500, 0, 0};
        vecs[4]  = '{1000, 0, 0, 625, 0, 0};
        vecs[5]  = '{1000, 0, 0, 750, 0, 0};
        vecs[6]  = '{1000, 0, 0, 875, 0, 0};
        vecs[7]  = '{1000, 0, 0, 1000, 0, 0};
        vecs[8]  = '{-1000, 80, -3, 750, 10, 0};
        vecs[9]  = '{-1000, 80, -5, 500, 20, -1};
        vecs[10] = '{32767, 4, -32768, 4471, 21, -4097};

        // Reset state and first sample tick
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_tick", sample_tick, 0);
        rst_n = 1'b1;
        n = 0;
        while (!sample_tick && n < 60000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tick_first", n, 49999);
        @(posedge clk);
        #1;
        check("tick_width", sample_tick, 0);

        // Moving average with default coefficients
        for (int i = 0; i < 11; i++) begin
            send({vecs[i].d2, vecs[i].d1, vecs[i].d0}, 1'b0, 1'b0, 3'd0, 16'd0, lat, r);
            check($sformatf("vec%0d_lat", i), lat, 25);
            check($sformatf("vec%0d_ch0", i), $signed(r[15:0]), vecs[i].e0);
            check($sformatf("vec%0d_ch1", i), $signed(r[31:16]), vecs[i].e1);
            check($sformatf("vec%0d_ch2", i), $signed(r[47:32]), vecs[i].e2);
            take();
        end

        // Overflow of the rounded result: wrap or clamp
        do_reset();
        for (int t = 0; t < 8; t++) begin
            wr_coef(3'(t), (t < 2) ? 16'h7FFF : 16'h0000);
        end
        send(48'h6000, 1'b0, 1'b0, 3'd0, 16'd0, lat, r);
        check("ovf_first", $signed(r[15:0]), 16'sh5FFF);
        take();
        send(48'h6000, 1'b0, 1'b0, 3'd0, 16'd0, lat, r);
        check("ovf_second", $signed(r[15:0]), exp_sat);
        check("ovf_ch1", $signed(r[31:16]), 0);
        take();

        // Coefficient write while busy is dropped, same-edge IDLE write is used
        do_reset();
        for (int t = 0; t < 8; t++) begin
            wr_coef(3'(t), 16'h0000);
        end
        send(48'd1000, 1'b0, 1'b1, 3'd3, 16'h4000, lat, r);
        check("cw_impulse", $signed(r[15:0]), 0);
        take();
        for (int k = 0; k < 3; k++) begin
            send(48'd0, 1'b0, 1'b0, 3'd0, 16'd0, lat, r);
            check($sformatf("cw_tap%0d", k + 1), $signed(r[15:0]), 0);
            take();
        end
        send(48'd0, 1'b1, 1'b0, 3'd4, 16'h4000, lat, r);
        check("cw_same_edge", $signed(r[15:0]), 500);
        take();

        // Reset in the middle of MAC
        in_data = 48'd1000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        check("mid_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_output", seen, 0);

        // Post-reset result and output hold under back-pressure
        send(48'd1000, 1'b0, 1'b0, 3'd0, 16'd0, lat, r);
        check("post_lat", lat, 25);
        check("post_ch0", $signed(r[15:0]), 125);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_data !== r || !out_valid) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_busy", busy, 1);
        take();
        check("done_out_valid", out_valid, 0);
        check("done_in_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
